// File: rtl/alu_operand_collector_if.sv
// Operand/command bus between the upstream issue logic, the collector and the ALU.
// Latency: none; this is wiring only.
// Backpressure: none; BUSY from the collector tells upstream when offers are not new commands.
interface alu_operand_collector_if #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4
);
    // Upstream side
    logic                 CE;
    logic                 MODE_IN;
    logic [CMD_WIDTH-1:0] CMD_IN;
    logic [WIDTH-1:0]     OPA_IN;
    logic [WIDTH-1:0]     OPB_IN;
    logic                 CIN_IN;
    logic [1:0]           INP_VALID_IN;

    // ALU side
    logic [WIDTH-1:0]     OPA;
    logic [WIDTH-1:0]     OPB;
    logic                 CIN;
    logic                 MODE;
    logic [CMD_WIDTH-1:0] CMD;
    logic [1:0]           INP_VALID;
    logic                 ISSUE;
    logic                 TIMEOUT_ERR;
    logic                 BUSY;

    // The collector itself
    modport slave (
        input  CE, MODE_IN, CMD_IN, OPA_IN, OPB_IN, CIN_IN, INP_VALID_IN,
        output OPA, OPB, CIN, MODE, CMD, INP_VALID, ISSUE, TIMEOUT_ERR, BUSY
    );

    // Whatever feeds the collector and watches its results
    modport master (
        output CE, MODE_IN, CMD_IN, OPA_IN, OPB_IN, CIN_IN, INP_VALID_IN,
        input  OPA, OPB, CIN, MODE, CMD, INP_VALID, ISSUE, TIMEOUT_ERR, BUSY
    );
endinterface

// File: rtl/alu_operand_collector.sv
// Collects the operands an ALU command needs (possibly over several cycles) and issues them together.
// Latency: the edge that completes the operand set raises ISSUE for the following cycle.
// Backpressure: none; offers during ISSUE are dropped, a missing operand times out after TIMEOUT WAIT cycles.
module alu_operand_collector #(
    parameter int WIDTH     = 8,
    parameter int CMD_WIDTH = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    alu_operand_collector_if.slave bus
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Shared ALU command codes (arithmetic mode)
    localparam logic [CMD_WIDTH-1:0] CMD_INC_A  = CMD_WIDTH'(4);
    localparam logic [CMD_WIDTH-1:0] CMD_DEC_A  = CMD_WIDTH'(5);
    localparam logic [CMD_WIDTH-1:0] CMD_INC_B  = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] CMD_DEC_B  = CMD_WIDTH'(7);
    // Shared ALU command codes (logical mode)
    localparam logic [CMD_WIDTH-1:0] CMD_NOT_A  = CMD_WIDTH'(6);
    localparam logic [CMD_WIDTH-1:0] CMD_NOT_B  = CMD_WIDTH'(7);
    localparam logic [CMD_WIDTH-1:0] CMD_SHR1_A = CMD_WIDTH'(8);
    localparam logic [CMD_WIDTH-1:0] CMD_SHL1_A = CMD_WIDTH'(9);
    localparam logic [CMD_WIDTH-1:0] CMD_SHR1_B = CMD_WIDTH'(10);
    localparam logic [CMD_WIDTH-1:0] CMD_SHL1_B = CMD_WIDTH'(11);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    // Operands a command needs: bit0 = A, bit1 = B. Anything not single-operand needs both.
    function automatic logic [1:0] req_mask(input logic mode, input logic [CMD_WIDTH-1:0] cmd);
        req_mask = 2'b11;
        if (mode) begin
            if (cmd == CMD_INC_A || cmd == CMD_DEC_A)      req_mask = 2'b01;
            else if (cmd == CMD_INC_B || cmd == CMD_DEC_B) req_mask = 2'b10;
        end else begin
            if (cmd == CMD_NOT_A || cmd == CMD_SHR1_A || cmd == CMD_SHL1_A)      req_mask = 2'b01;
            else if (cmd == CMD_NOT_B || cmd == CMD_SHR1_B || cmd == CMD_SHL1_B) req_mask = 2'b10;
        end
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           coll_q, coll_d;
    logic [1:0]           req_q, req_d;
    logic [1:0]           req_now;
    logic [1:0]           inp_valid_q, inp_valid_d;
    logic                 issue_q, issue_d;
    logic                 tmo_q, tmo_d;
    logic                 take_a, take_b, take_ctl;
    logic [WIDTH-1:0]     opa_q, opb_q;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic                 mode_q, cin_q;

    assign req_now = req_mask(bus.MODE_IN, bus.CMD_IN);

    // State register and pulse outputs; everything freezes while CE is low
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            coll_q      <= 2'b00;
            req_q       <= 2'b00;
            inp_valid_q <= 2'b00;
            issue_q     <= 1'b0;
            tmo_q       <= 1'b0;
        end else if (bus.CE) begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            coll_q      <= coll_d;
            req_q       <= req_d;
            inp_valid_q <= inp_valid_d;
            issue_q     <= issue_d;
            tmo_q       <= tmo_d;
        end
    end

    // Next state, which inputs to capture, and the pulses for the next cycle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        coll_d      = coll_q;
        req_d       = req_q;
        inp_valid_d = 2'b00;
        issue_d     = 1'b0;
        tmo_d       = 1'b0;
        take_a      = 1'b0;
        take_b      = 1'b0;
        take_ctl    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.INP_VALID_IN != 2'b00) begin
                    take_ctl = 1'b1;
                    take_a   = bus.INP_VALID_IN[0];
                    take_b   = bus.INP_VALID_IN[1];
                    req_d    = req_now;
                    coll_d   = bus.INP_VALID_IN;
                    cnt_d    = '0;
                    if ((coll_d & req_d) == req_d) begin
                        state_d     = S_ISSUE;
                        issue_d     = 1'b1;
                        inp_valid_d = coll_d;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Only fill holes; operands already held are never replaced
                take_a = bus.INP_VALID_IN[0] & ~coll_q[0];
                take_b = bus.INP_VALID_IN[1] & ~coll_q[1];
                coll_d = coll_q | bus.INP_VALID_IN;
                if ((coll_d & req_q) == req_q) begin
                    state_d     = S_ISSUE;
                    issue_d     = 1'b1;
                    inp_valid_d = coll_d;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    tmo_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ISSUE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operand and command holding registers, which drive the ALU directly
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opa_q  <= '0;
            opb_q  <= '0;
            cmd_q  <= '0;
            mode_q <= 1'b0;
            cin_q  <= 1'b0;
        end else if (bus.CE) begin
            if (take_a) opa_q <= bus.OPA_IN;
            if (take_b) opb_q <= bus.OPB_IN;
            if (take_ctl) begin
                cmd_q  <= bus.CMD_IN;
                mode_q <= bus.MODE_IN;
                cin_q  <= bus.CIN_IN;
            end
        end
    end

    assign bus.OPA         = opa_q;
    assign bus.OPB         = opb_q;
    assign bus.CMD         = cmd_q;
    assign bus.MODE        = mode_q;
    assign bus.CIN         = cin_q;
    assign bus.INP_VALID   = inp_valid_q;
    assign bus.ISSUE       = issue_q;
    assign bus.TIMEOUT_ERR = tmo_q;
    assign bus.BUSY        = (state_q != S_IDLE);
endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector with hand-computed expectations.
// Inputs change 1 ns after a rising edge and outputs are sampled at the same point.
// Status vector layout: {OPA, OPB, CMD, MODE, CIN, INP_VALID, ISSUE, TIMEOUT_ERR, BUSY}.
module tb_alu_operand_collector;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    alu_operand_collector_if #(.WIDTH(8), .CMD_WIDTH(4)) bus ();

    alu_operand_collector #(.WIDTH(8), .CMD_WIDTH(4), .TIMEOUT(16)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [26:0] obs;
    assign obs = {bus.OPA, bus.OPB, bus.CMD, bus.MODE, bus.CIN, bus.INP_VALID,
                  bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (obs !== 27'h0) begin
            failures++; $display("FAIL reset_async got=%h exp=%h", obs, 27'h0);
        end
        tick();
        checks++;
        if (obs !== 27'h0) begin
            failures++; $display("FAIL reset_held got=%h exp=%h", obs, 27'h0);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs !== 27'h0) begin
            failures++; $display("FAIL reset_idle got=%h exp=%h", obs, 27'h0);
        end
    endtask

    task automatic test_add_both();
        bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd0; bus.CIN_IN = 1'b0;
        bus.OPA_IN = 8'h12; bus.OPB_IN = 8'h34; bus.INP_VALID_IN = 2'b11;
        tick();
        checks++;
        if (obs !== {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL add_issue got=%h exp=%h", obs, {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1});
        end
        // Offer during ISSUE must be ignored
        bus.OPA_IN = 8'hAA; bus.OPB_IN = 8'hBB; bus.CMD_IN = 4'd3; bus.MODE_IN = 1'b0;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL add_after got=%h exp=%h", obs, {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        end
        tick();
        checks++;
        if (obs !== {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0}) begin
            failures++; $display("FAIL issue_ignored got=%h exp=%h", obs, {8'h12, 8'h34, 4'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_single_operand();
        bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd4; bus.CIN_IN = 1'b0;
        bus.OPA_IN = 8'hFF; bus.OPB_IN = 8'hBB; bus.INP_VALID_IN = 2'b01;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'hFF, 8'h34, 4'd4, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL inc_a_issue got=%h exp=%h", obs, {8'hFF, 8'h34, 4'd4, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1});
        end
        tick();
        checks++;
        if ({bus.INP_VALID, bus.ISSUE, bus.BUSY} !== 4'b0000) begin
            failures++; $display("FAIL inc_a_done got=%b exp=%b", {bus.INP_VALID, bus.ISSUE, bus.BUSY}, 4'b0000);
        end
        // Unrequired B arriving with A is still latched and flagged
        bus.OPA_IN = 8'h01; bus.OPB_IN = 8'h02; bus.INP_VALID_IN = 2'b11;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'h01, 8'h02, 4'd4, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL unrequired_b got=%h exp=%h", obs, {8'h01, 8'h02, 4'd4, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1});
        end
        tick();
    endtask

    task automatic test_wait_collect();
        bus.MODE_IN = 1'b0; bus.CMD_IN = 4'd0; bus.CIN_IN = 1'b1;
        bus.OPA_IN = 8'hF0; bus.OPB_IN = 8'h99; bus.INP_VALID_IN = 2'b01;
        tick();
        checks++;
        if (obs !== {8'hF0, 8'h02, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL and_wait got=%h exp=%h", obs, {8'hF0, 8'h02, 4'd0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1});
        end
        bus.CMD_IN = 4'd5; bus.MODE_IN = 1'b1; bus.CIN_IN = 1'b0; bus.OPA_IN = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            bus.INP_VALID_IN = (i == 2) ? 2'b01 : 2'b00;
            tick();
            checks++;
            if ({bus.OPA, bus.INP_VALID, bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY} !== {8'hF0, 2'b00, 1'b0, 1'b0, 1'b1}) begin
                failures++; $display("FAIL and_midwait cycle=%0d got=%h exp=%h", i,
                    {bus.OPA, bus.INP_VALID, bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY}, {8'hF0, 2'b00, 1'b0, 1'b0, 1'b1});
            end
        end
        bus.OPB_IN = 8'h3C; bus.INP_VALID_IN = 2'b10;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'hF0, 8'h3C, 4'd0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL and_issue got=%h exp=%h", obs, {8'hF0, 8'h3C, 4'd0, 1'b0, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1});
        end
        tick();
    endtask

    task automatic test_timeout();
        bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd1; bus.CIN_IN = 1'b0;
        bus.OPB_IN = 8'h55; bus.INP_VALID_IN = 2'b10;
        tick();
        bus.INP_VALID_IN = 2'b00;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++;
            if ({bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY} !== 3'b001) begin
                failures++; $display("FAIL timeout_early cycle=%0d got=%b exp=%b", i, {bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY}, 3'b001);
            end
        end
        tick();
        checks++;
        if (obs !== {8'hF0, 8'h55, 4'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL timeout_pulse got=%h exp=%h", obs, {8'hF0, 8'h55, 4'd1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
        end
        tick();
        checks++;
        if ({bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY} !== 3'b000) begin
            failures++; $display("FAIL timeout_oneshot got=%b exp=%b", {bus.ISSUE, bus.TIMEOUT_ERR, bus.BUSY}, 3'b000);
        end
        // Missing operand arriving on the last allowed WAIT cycle
        bus.OPB_IN = 8'h07; bus.INP_VALID_IN = 2'b10;
        tick();
        bus.INP_VALID_IN = 2'b00;
        for (int i = 1; i <= 15; i++) tick();
        bus.OPA_IN = 8'h09; bus.INP_VALID_IN = 2'b01;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'h09, 8'h07, 4'd1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL last_cycle_issue got=%h exp=%h", obs, {8'h09, 8'h07, 4'd1, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1});
        end
        tick();
    endtask

    task automatic test_ce_freeze();
        bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd1; bus.OPB_IN = 8'h21; bus.INP_VALID_IN = 2'b10;
        tick();
        bus.INP_VALID_IN = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        bus.CE = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if ({bus.TIMEOUT_ERR, bus.BUSY} !== 2'b01) begin
                failures++; $display("FAIL ce_frozen cycle=%0d got=%b exp=%b", i, {bus.TIMEOUT_ERR, bus.BUSY}, 2'b01);
            end
        end
        bus.CE = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({bus.TIMEOUT_ERR, bus.BUSY} !== 2'b01) begin
                failures++; $display("FAIL ce_resume cycle=%0d got=%b exp=%b", i, {bus.TIMEOUT_ERR, bus.BUSY}, 2'b01);
            end
        end
        tick();
        checks++;
        if ({bus.TIMEOUT_ERR, bus.BUSY} !== 2'b10) begin
            failures++; $display("FAIL ce_timeout got=%b exp=%b", {bus.TIMEOUT_ERR, bus.BUSY}, 2'b10);
        end
        bus.CE = 1'b0;
        tick();
        checks++;
        if (bus.TIMEOUT_ERR !== 1'b1) begin
            failures++; $display("FAIL ce_err_hold got=%b exp=%b", bus.TIMEOUT_ERR, 1'b1);
        end
        bus.CE = 1'b1;
        tick();
        checks++;
        if (bus.TIMEOUT_ERR !== 1'b0) begin
            failures++; $display("FAIL ce_err_clear got=%b exp=%b", bus.TIMEOUT_ERR, 1'b0);
        end
        // ISSUE pulse also stretches while CE is low
        bus.CMD_IN = 4'd0; bus.OPA_IN = 8'h11; bus.OPB_IN = 8'h22; bus.INP_VALID_IN = 2'b11;
        tick();
        bus.INP_VALID_IN = 2'b00;
        bus.CE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.ISSUE, bus.INP_VALID, bus.BUSY} !== 4'b1111) begin
                failures++; $display("FAIL ce_issue_hold cycle=%0d got=%b exp=%b", i, {bus.ISSUE, bus.INP_VALID, bus.BUSY}, 4'b1111);
            end
        end
        bus.CE = 1'b1;
        tick();
        checks++;
        if ({bus.ISSUE, bus.INP_VALID, bus.BUSY} !== 4'b0000) begin
            failures++; $display("FAIL ce_issue_clear got=%b exp=%b", {bus.ISSUE, bus.INP_VALID, bus.BUSY}, 4'b0000);
        end
    endtask

    task automatic test_mask_decode();
        // {mode, cmd, valid offered, issue expected immediately}
        logic [7:0] vec [16];
        vec = '{ {1'b1, 4'd4,  2'b01, 1'b1}, {1'b1, 4'd5,  2'b01, 1'b1},
                 {1'b1, 4'd6,  2'b10, 1'b1}, {1'b1, 4'd7,  2'b10, 1'b1},
                 {1'b1, 4'd6,  2'b01, 1'b0}, {1'b1, 4'd0,  2'b01, 1'b0},
                 {1'b1, 4'd15, 2'b01, 1'b0}, {1'b0, 4'd6,  2'b01, 1'b1},
                 {1'b0, 4'd7,  2'b10, 1'b1}, {1'b0, 4'd8,  2'b01, 1'b1},
                 {1'b0, 4'd9,  2'b01, 1'b1}, {1'b0, 4'd10, 2'b10, 1'b1},
                 {1'b0, 4'd11, 2'b10, 1'b1}, {1'b0, 4'd6,  2'b10, 1'b0},
                 {1'b0, 4'd4,  2'b01, 1'b0}, {1'b0, 4'd15, 2'b10, 1'b0} };
        for (int i = 0; i < 16; i++) begin
            bus.MODE_IN = vec[i][7]; bus.CMD_IN = vec[i][6:3]; bus.INP_VALID_IN = vec[i][2:1];
            tick();
            checks++;
            if (bus.ISSUE !== vec[i][0]) begin
                failures++; $display("FAIL mask_decode entry=%0d got=%b exp=%b", i, bus.ISSUE, vec[i][0]);
            end
            bus.INP_VALID_IN = 2'b11;
            tick();
            bus.INP_VALID_IN = 2'b00;
            tick();
            checks++;
            if (bus.BUSY !== 1'b0) begin
                failures++; $display("FAIL mask_drain entry=%0d got=%b exp=%b", i, bus.BUSY, 1'b0);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        bus.MODE_IN = 1'b1; bus.CMD_IN = 4'd1; bus.CIN_IN = 1'b1;
        bus.OPB_IN = 8'hAB; bus.INP_VALID_IN = 2'b10;
        tick();
        bus.INP_VALID_IN = 2'b00;
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 27'h0) begin
            failures++; $display("FAIL reset_mid_wait got=%h exp=%h", obs, 27'h0);
        end
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.ISSUE !== 1'b0 || bus.TIMEOUT_ERR !== 1'b0 || bus.BUSY !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++; $display("FAIL reset_discard got=%b exp=%b", seen, 1'b0);
        end
        bus.CMD_IN = 4'd0; bus.CIN_IN = 1'b0; bus.OPA_IN = 8'h5A; bus.OPB_IN = 8'hA5; bus.INP_VALID_IN = 2'b11;
        tick();
        bus.INP_VALID_IN = 2'b00;
        checks++;
        if (obs !== {8'h5A, 8'hA5, 4'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1}) begin
            failures++; $display("FAIL post_reset_issue got=%h exp=%h", obs, {8'h5A, 8'hA5, 4'd0, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1});
        end
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.CE = 1'b1;
        bus.MODE_IN = 1'b0;
        bus.CMD_IN = 4'd0;
        bus.OPA_IN = 8'h00;
        bus.OPB_IN = 8'h00;
        bus.CIN_IN = 1'b0;
        bus.INP_VALID_IN = 2'b00;
        test_reset();
        test_add_both();
        test_single_operand();
        test_wait_collect();
        test_timeout();
        test_ce_freeze();
        test_mask_decode();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
